// File: rtl/metro_mpi_pkg.sv
// Shared constants for the MPI flit link (credit sender / receiver pair).
package metro_mpi_pkg;
  localparam int          DATA_WIDTH   = 64;
  localparam int          NUM_CREDITS  = 7;
  localparam int          CREDIT_WIDTH = $clog2(NUM_CREDITS + 1);
  localparam logic [63:0] SEQ_SEED     = 64'hcafe_cafe_cafe_cafe;
endpackage

// File: rtl/receiver_fifo.sv
// Synchronous FIFO; head is a combinational read of the slot at rd_ptr, so a
// write becomes visible the cycle after it lands (no write-to-read bypass).
module receiver_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PW-1:0]                    wr_ptr, rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage: not reset, contents are only meaningful under count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/receiver_mpi.sv
// Receiving end of the credit-based MPI flit link: buffers flits, hands them
// to a local consumer, returns one credit per drained flit, and checks the
// sender's incrementing payload sequence.
module receiver_mpi #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int RX_RANK    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  int                    rank_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  yummy_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic                  seq_err_o,
  output logic [31:0]           rx_count_o
);
  import metro_mpi_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic                  active, push, pop, full, empty, yummy_q;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head, expected_q;

  assign active = (rank_i == RX_RANK);
  assign valid_o = active & ~empty;
  assign data_o  = valid_o ? head : '0;
  assign pop     = valid_o & ready_i;
  // A full FIFO can still take a flit when the head leaves in the same cycle.
  assign push    = active & valid_i & (~full | pop);
  // Credits are suppressed while this rank is not the receiver.
  assign yummy_o = yummy_q & active;

  receiver_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (data_i),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Credit return, sticky error flags, flit counter and sequence tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yummy_q    <= 1'b0;
      overflow_o <= 1'b0;
      seq_err_o  <= 1'b0;
      rx_count_o <= '0;
      expected_q <= DATA_WIDTH'(SEQ_SEED);
    end else begin
      yummy_q <= pop;
      if (active & valid_i & ~push) overflow_o <= 1'b1;
      if (push) begin
        rx_count_o <= rx_count_o + 32'd1;
        if (data_i != expected_q) seq_err_o <= 1'b1;
        // Resynchronise on the received value so one glitch flags once.
        expected_q <= data_i + DATA_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_receiver_mpi.sv
// Directed bench for receiver_mpi with a scoreboard queue of buffered flits.
module tb_receiver_mpi;
  localparam logic [63:0] SEED = 64'hcafe_cafe_cafe_cafe;

  logic        clk = 0, rst_i = 1, valid_i = 0, ready_i = 0;
  int          rank_i = 1;
  logic [63:0] data_i = '0, data_o;
  logic        yummy_o, valid_o, overflow_o, seq_err_o;
  logic [31:0] rx_count_o;

  int errors = 0, checks = 0, yummies = 0;

  // Scoreboard / reference state.
  logic [63:0] q[$];
  logic        m_yummy = 0, m_ovf = 0, m_seq = 0;
  logic [31:0] m_cnt = 0;
  logic [63:0] m_exp = SEED;

  always #5 clk = ~clk;

  receiver_mpi dut (
    .clk_i(clk), .rst_i(rst_i), .rank_i(rank_i), .valid_i(valid_i),
    .data_i(data_i), .yummy_o(yummy_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .overflow_o(overflow_o), .seq_err_o(seq_err_o),
    .rx_count_o(rx_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge against the model, then advance the model.
  task automatic tick();
    logic act, mvalid, mpop, mpush;
    @(negedge clk);
    act    = (rank_i == 1);
    mvalid = act && (q.size() > 0);
    chk("valid_o", 64'(valid_o), 64'(mvalid));
    chk("data_o", data_o, mvalid ? q[0] : 64'h0);
    chk("yummy_o", 64'(yummy_o), 64'(act & m_yummy));
    chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
    chk("seq_err_o", 64'(seq_err_o), 64'(m_seq));
    chk("rx_count_o", 64'(rx_count_o), 64'(m_cnt));
    chk("count", 64'(dut.u_fifo.count), 64'(q.size()));
    if (yummy_o) yummies++;
    mpop  = mvalid && ready_i;
    mpush = act && valid_i && ((q.size() < 8) || mpop);
    @(posedge clk);
    if (rst_i) begin
      q.delete(); m_yummy = 0; m_ovf = 0; m_seq = 0; m_cnt = 0; m_exp = SEED;
    end else begin
      m_yummy = mpop;
      if (act && valid_i && !mpush) m_ovf = 1;
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(data_i);
        if (data_i != m_exp) m_seq = 1;
        m_exp = data_i + 64'd1;
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    valid_i = 0; ready_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic send(input logic [63:0] d);
    valid_i = 1; data_i = d;
    tick();
    valid_i = 0;
  endtask

  initial begin
    // Power-up reset; outputs are unknown before the first edge.
    rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("rst valid_o", 64'(valid_o), 64'h0);
    chk("rst yummy_o", 64'(yummy_o), 64'h0);
    chk("rst rx_count_o", 64'(rx_count_o), 64'h0);
    chk("rst expected_q", dut.expected_q, SEED);
    @(posedge clk); #1;

    // Seven back-to-back flits, consumer stalled.
    for (int i = 0; i < 7; i++) send(SEED + 64'(i));
    tick();
    chk("fill7 data_o", data_o, SEED);
    chk("fill7 count", 64'(dut.u_fifo.count), 64'd7);
    chk("fill7 rx_count", 64'(rx_count_o), 64'd7);

    // Drain: seven pops, seven back-to-back credits.
    yummies = 0;
    ready_i = 1;
    repeat (7) tick();
    ready_i = 0;
    repeat (2) tick();
    chk("drain yummies", 64'(yummies), 64'd7);
    chk("drain valid_o", 64'(valid_o), 64'h0);

    // Fill to DEPTH, then a ninth flit overflows and is dropped.
    do_reset();
    for (int i = 0; i < 8; i++) send(SEED + 64'(i));
    send(SEED + 64'd8);
    tick();
    chk("ovf flag", 64'(overflow_o), 64'h1);
    chk("ovf count", 64'(dut.u_fifo.count), 64'd8);
    chk("ovf rx_count", 64'(rx_count_o), 64'd8);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) send(SEED + 64'(i));
    yummies = 0;
    ready_i = 1; valid_i = 1; data_i = SEED + 64'd8;
    tick();
    ready_i = 0; valid_i = 0;
    tick();
    chk("pp count", 64'(dut.u_fifo.count), 64'd8);
    chk("pp overflow", 64'(overflow_o), 64'h0);
    chk("pp yummies", 64'(yummies), 64'd1);
    chk("pp rx_count", 64'(rx_count_o), 64'd9);

    // Sequence break and resynchronisation.
    do_reset();
    send(SEED); send(SEED + 64'd1);
    tick();
    chk("seq ok", 64'(seq_err_o), 64'h0);
    send(64'h1234);
    tick();
    chk("seq err", 64'(seq_err_o), 64'h1);
    send(64'h1235);
    tick();
    chk("seq expected_q", dut.expected_q, 64'h1236);

    // Inactive rank: nothing stored, nothing popped, no credits.
    do_reset();
    send(SEED); send(SEED + 64'd1);
    rank_i = 0;
    ready_i = 1;
    send(SEED + 64'd2); send(SEED + 64'd3);
    tick();
    chk("rank count", 64'(dut.u_fifo.count), 64'd2);
    chk("rank yummy", 64'(yummy_o), 64'h0);
    chk("rank data_o", data_o, 64'h0);
    ready_i = 0;
    rank_i = 1;
    tick();

    // Reset with three entries buffered.
    do_reset();
    send(SEED); send(SEED + 64'd1); send(64'h55);
    send(64'h77);
    ready_i = 1;
    tick();
    ready_i = 0;
    do_reset();
    @(negedge clk);
    chk("rst2 count", 64'(dut.u_fifo.count), 64'd0);
    chk("rst2 valid_o", 64'(valid_o), 64'h0);
    chk("rst2 overflow", 64'(overflow_o), 64'h0);
    chk("rst2 seq_err", 64'(seq_err_o), 64'h0);
    chk("rst2 yummy", 64'(yummy_o), 64'h0);
    chk("rst2 expected_q", dut.expected_q, SEED);
    @(posedge clk); #1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/receiver_mpi.md
Name: receiver_mpi

Overview:
Receiving end of the credit-based MPI flit link; the transmitting end is the credit sender.
- Accepts valid_i/data_i flits into a local FIFO.
- Presents them to a local consumer through a valid/ready interface.
- Returns one yummy_o credit pulse per flit the consumer drains.
- Checks that received payloads follow the sender's incrementing sequence; flags overflow and sequence errors.

Parameters:
DEPTH, 8, FIFO entries; must be >= NUM_CREDITS (package constant, 7).
DATA_WIDTH, 64, flit payload width.
RX_RANK, 1, rank value for which the block is active.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
rank_i  input  int  MPI rank of this process; block active only when rank_i == RX_RANK
valid_i  input  1  flit valid from link
data_i  input  DATA_WIDTH  flit payload from link
yummy_o  output  1  credit return pulse to sender
data_o  output  DATA_WIDTH  head-of-FIFO payload to consumer
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts head this cycle
overflow_o  output  1  sticky: flit arrived with no space
seq_err_o  output  1  sticky: payload != expected sequence value
rx_count_o  output  32  total flits accepted

Behaviour:
- All state changes on posedge clk_i.
- rst_i=1 synchronously clears the following: wr/rd pointers, count=0, yummy_o=0, overflow_o=0, seq_err_o=0, rx_count_o=0, expected_q=SEQ_SEED (64'hcafe_cafe_cafe_cafe).
- Reset mid-operation discards buffered flits and issues no credits for them; the system resets the sender in the same cycle so both ends restart at 7 credits / empty.
- Inactive (rank_i != RX_RANK): no push, no pop, yummy_o=0, valid_o=0, data_o=0; stored state held.
- push = active & valid_i & (count<DEPTH | pop).
  - Writes data_i at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - rx_count_o += 1 with 32-bit wrap.
- Overflow: active & valid_i & ~push sets overflow_o; the flit is dropped.
- pop = active & valid_o & ready_i; rd_ptr advances with wrap.
- Simultaneous push and pop: count unchanged, including when count == DEPTH.
- Latency: a flit pushed at cycle N is visible on valid_o/data_o at cycle N+1; there is no write-to-read bypass.
- When empty, valid_o=0 and data_o=0. data_o is the registered storage read at rd_ptr.
- Credit return: yummy_o is a registered copy of pop, high for exactly one cycle in the cycle after each pop. Back-to-back pops produce back-to-back yummy pulses.
- Sequence check on every push:
  - data_i != expected_q sets seq_err_o.
  - expected_q <= data_i + 1 (resynchronises to the received value), 64-bit wrap.
- count width is $clog2(DEPTH+1). Pointers are $clog2(DEPTH) bits; DEPTH is a power of two.
- Credit invariant: with a compliant sender, count + in-flight yummies <= NUM_CREDITS, so overflow_o stays 0.

Decomposition:
- metro_mpi_pkg gains: DATA_WIDTH=64, NUM_CREDITS=7, SEQ_SEED=64'hcafe_cafe_cafe_cafe.
- The existing CREDIT_WIDTH is reused for count sizing checks.
- One sub-module, receiver_fifo: parameterised DEPTH/DATA_WIDTH synchronous FIFO with push, pop, full, empty, count, head data.
- receiver_mpi holds the rank gating, yummy register, sequence checker and counters.

Test Plan:
- Reset, then 7 back-to-back flits cafe..cafe through cafe..cafe+6 with ready_i=0:
  - count=7, valid_o=1, data_o=64'hcafe_cafe_cafe_cafe;
  - no yummy_o; seq_err_o=0; rx_count_o=7.
- Then ready_i=1 for 7 cycles:
  - data_o steps cafe..cafe+6;
  - yummy_o high for 7 consecutive cycles, each one cycle after its pop;
  - valid_o=0 afterwards.
- Fill to DEPTH=8 with ready_i=0, then a 9th valid_i:
  - overflow_o=1; count stays 8; rx_count_o=8.
- Full FIFO, same cycle valid_i=1 and ready_i=1:
  - push accepted; count stays 8; overflow_o=0; one yummy next cycle.
- Flit sequence cafe, cafe+1, 0x1234, 0x1235:
  - seq_err_o=1 from the cycle after 0x1234;
  - expected_q=0x1236 at end.
- Set rank_i=0 with valid_i=1:
  - nothing stored; yummy_o=0.
- Assert rst_i with 3 entries buffered:
  - next cycle count=0, valid_o=0, all flags 0, expected_q=SEED.
